// File: rtl/regfile_write_queue.sv
// Write-side result queue in front of the register file: in-order drain through a registered
// write port, plus two combinational forwarding lookups over everything still pending.
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_dest,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        fwd_addr1,
  output logic                     fwd_hit1,
  output logic [DATA_W-1:0]        fwd_data1,
  input  logic [ADDR_W-1:0]        fwd_addr2,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } fwd_t;

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              push, pop;
  fwd_t              fwd1, fwd2;

  assign in_ready = !reset && (count_q < CNT_W'(DEPTH));
  // Writes to r0 complete the handshake but are dropped.
  assign push     = in_valid && in_ready && (in_dest != '0);
  assign pop      = (count_q != '0) && drain_en;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      wr_addr_d = dest_q[rd_ptr_q];
      wr_data_d = data_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= pop;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr_q] <= in_dest;
      data_q[wr_ptr_q] <= in_data;
    end
  end

  // Scan oldest to newest so the most recently accepted match overrides earlier ones.
  function automatic fwd_t lookup(input logic [ADDR_W-1:0] addr);
    fwd_t             r;
    logic [PTR_W-1:0] idx;
    r = '0;
    if (!reset && addr != '0) begin
      if (wr_en_q && wr_addr_q == addr) begin
        r.hit  = 1'b1;
        r.data = wr_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PTR_W'(i);
        if (CNT_W'(i) < count_q && dest_q[idx] == addr) begin
          r.hit  = 1'b1;
          r.data = data_q[idx];
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    fwd1 = lookup(fwd_addr1);
    fwd2 = lookup(fwd_addr2);
  end

  assign fwd_hit1  = fwd1.hit;
  assign fwd_data1 = fwd1.data;
  assign fwd_hit2  = fwd2.hit;
  assign fwd_data2 = fwd2.data;

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;
  assign idle    = (count_q == '0) && !wr_en_q;

endmodule
